// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: ALU opcodes, FSM states
// and the 16-bit instruction layout.
package seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_CMP = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WB,
    ST_DONE
  } seq_state_e;

  localparam int INSTR_W     = 16;
  localparam int OPC_HI      = 15;
  localparam int OPC_LO      = 13;
  localparam int RD_HI       = 12;
  localparam int RD_LO       = 11;
  localparam int RA_HI       = 10;
  localparam int RA_LO       = 9;
  localparam int USE_IMM_BIT = 8;
  localparam int IMM_HI      = 7;
  localparam int IMM_LO      = 0;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] rd;
    logic [1:0] ra;
    logic       use_imm;
    logic [7:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.opcode  = w[OPC_HI:OPC_LO];
    d.rd      = w[RD_HI:RD_LO];
    d.ra      = w[RA_HI:RA_LO];
    d.use_imm = w[USE_IMM_BIT];
    d.imm     = w[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// Four 8-bit registers with one write port and combinational read ports
// for operand A, operand B and the debug tap.
module seq_regfile
  import seq_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] ra_sel,
  input  logic [1:0] rb_sel,
  input  logic [1:0] dbg_sel,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  output logic [7:0] dbg_data
);

  logic [7:0] regs_q [NREGS];
  logic [7:0] regs_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ra_data  = regs_q[ra_sel];
  assign rb_data  = regs_q[rb_sel];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/program_sequencer.sv
// Runs a small loaded program against an external ALU: fetch, issue
// operands, write the result back; one instruction every three cycles.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int NREGS      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_wdata,
  output logic [2:0]        opcode,
  output logic [7:0]        a,
  output logic [7:0]        b,
  input  logic [7:0]        alu_out,
  input  logic              carry_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pc,
  output logic              carry_flag,
  output logic              div0_err,
  input  logic [1:0]        dbg_sel,
  output logic [7:0]        dbg_data
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W:0] PC_ONE  = (ADDR_W+1)'(1);

  logic [INSTR_W-1:0] mem_q [PROG_DEPTH];

  seq_state_e      state_q, state_d;
  logic [ADDR_W:0] pc_q, pc_d;
  logic [ADDR_W:0] len_q, len_d;
  instr_t          ir_q, ir_d;
  logic [2:0]      opcode_q, opcode_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            carry_q, carry_d;
  logic            div0_q, div0_d;

  logic            mem_we;
  logic            rf_we;
  logic [7:0]      rf_ra_data;
  logic [7:0]      rf_rb_data;
  logic [ADDR_W:0] start_len;
  logic [ADDR_W:0] pc_inc;

  // Writes are only honoured while parked, so a running program never
  // sees its own code change underneath it.
  assign mem_we = prog_we && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[prog_addr] <= prog_wdata;
  end

  assign start_len = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign pc_inc    = pc_q + PC_ONE;

  seq_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (reset),
    .we       (rf_we),
    .waddr    (ir_q.rd),
    .wdata    (alu_out),
    .ra_sel   (ir_q.ra),
    .rb_sel   (ir_q.imm[1:0]),
    .dbg_sel  (dbg_sel),
    .ra_data  (rf_ra_data),
    .rb_data  (rf_rb_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    ir_d     = ir_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    div0_d   = div0_q;
    rf_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = start_len;
          pc_d    = '0;
          div0_d  = 1'b0;
          state_d = (start_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = decode_instr(mem_q[pc_q[ADDR_W-1:0]]);
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        opcode_d = ir_q.opcode;
        a_d      = rf_ra_data;
        b_d      = ir_q.use_imm ? ir_q.imm : rf_rb_data;
        state_d  = ST_WB;
      end
      ST_WB: begin
        // Result lands before the next ISSUE, so back-to-back dependencies
        // read the fresh value without any bypass.
        rf_we   = 1'b1;
        carry_d = carry_out;
        if ((opcode_q == OP_DIV) && (b_q == 8'd0)) div0_d = 1'b1;
        pc_d    = pc_inc;
        state_d = (pc_inc == len_q) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_WB);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      ir_q     <= '0;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      ir_q     <= ir_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
      div0_q   <= div0_d;
    end
  end

  assign opcode     = opcode_q;
  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pc         = pc_q;
  assign carry_flag = carry_q;
  assign div0_err   = div0_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a stand-in ALU, a program-level reference
// model and cycle-exact checks of issue, writeback and completion.
module tb_program_sequencer;

  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR  = 3'd3;
  localparam logic [2:0] A_XOR = 3'd4, A_MUL = 3'd5, A_DIV = 3'd6, A_CMP = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  prog_len;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [2:0]  opcode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  alu_out;
  logic        carry_out;
  logic        busy;
  logic        done;
  logic [4:0]  pc;
  logic        carry_flag;
  logic        div0_err;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  program_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_len   (prog_len),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .alu_out    (alu_out),
    .carry_out  (carry_out),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .carry_flag (carry_flag),
    .div0_err   (div0_err),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ALU stand-in ----------------
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    case (op)
      A_ADD: return {1'b0, x} + {1'b0, y};
      A_SUB: return {(x < y), 8'(x - y)};
      A_AND: return {1'b0, x & y};
      A_OR:  return {1'b0, x | y};
      A_XOR: return {1'b0, x ^ y};
      A_MUL: begin
        p = 16'(x) * 16'(y);
        return {|p[15:8], p[7:0]};
      end
      A_DIV: return (y == 8'd0) ? 9'h100 : {1'b0, x / y};
      default: return {(x < y), 7'd0, (x == y)};
    endcase
  endfunction

  always_comb {carry_out, alu_out} = alu_fn(opcode, a, b);

  // ---------------- reference model + scoreboard ----------------
  logic [15:0] mdl_mem [16];
  logic [7:0]  mdl_reg [4];
  logic        mdl_carry;
  logic        mdl_div0;
  logic [18:0] exp_q [$];
  logic [15:0] prog_buf [$];
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                                      input logic use_imm, input logic [7:0] imm);
    return {op, rd, ra, use_imm, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl_reg[i] = 8'd0;
    mdl_carry = 1'b0;
    mdl_div0  = 1'b0;
    exp_q.delete();
  endtask

  // Executes the first n program words and queues the operands each one should issue.
  task automatic model_run(input int n);
    logic [15:0] w;
    logic [7:0]  xa, xb;
    logic [8:0]  r;
    for (int i = 0; i < n; i++) begin
      w  = mdl_mem[i];
      xa = mdl_reg[w[10:9]];
      xb = w[8] ? w[7:0] : mdl_reg[w[1:0]];
      exp_q.push_back({w[15:13], xa, xb});
      r = alu_fn(w[15:13], xa, xb);
      mdl_reg[w[12:11]] = r[7:0];
      mdl_carry = r[8];
      if (w[15:13] == A_DIV && xb == 8'd0) mdl_div0 = 1'b1;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check_eq($sformatf("%s_reg%0d", tag, i), dbg_data, mdl_reg[i]);
    end
  endtask

  task automatic check_reg_const(input int idx, input logic [7:0] val);
    dbg_sel = 2'(idx);
    #1;
    check_eq($sformatf("const_reg%0d", idx), dbg_data, val);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_opcode"}, opcode, 0);
    check_eq({tag, "_a"}, a, 0);
    check_eq({tag, "_b"}, b, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pc"}, pc, 0);
    check_eq({tag, "_carry"}, carry_flag, 0);
    check_eq({tag, "_div0"}, div0_err, 0);
    check_regs(tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_state("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [15:0] w);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = addr;
    prog_wdata = w;
    mdl_mem[addr] = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_buf();
    for (int i = 0; i < prog_buf.size(); i++) write_word(4'(i), prog_buf[i]);
    prog_buf.delete();
  endtask

  // mode 0: plain run; 1: start and prog_we pulsed mid-run (both must be ignored);
  // 2: word 0 rewritten on the start edge itself.
  task automatic run_prog(input logic [4:0] plen, input int mode, input logic [15:0] new_word);
    int n;
    n = (plen > 5'd16) ? 16 : int'(plen);
    @(negedge clk);
    start    = 1'b1;
    prog_len = plen;
    if (mode == 2) begin
      prog_we    = 1'b1;
      prog_addr  = 4'd0;
      prog_wdata = new_word;
      mdl_mem[0] = new_word;
    end
    mdl_div0 = 1'b0;
    model_run(n);
    for (int cyc = 1; cyc <= 3 * n + 1; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      prog_we = 1'b0;
      if (mode == 1 && cyc == 4) begin
        start      = 1'b1;
        prog_len   = 5'd1;
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = 16'($urandom);
      end
      if (cyc <= 3 * n) begin
        check_eq("busy_run", busy, 1);
        check_eq("done_early", done, 0);
        if (cyc % 3 == 0) begin
          check_eq("pc_run", pc, cyc / 3 - 1);
          check_eq("issue_op_a_b", {opcode, a, b}, exp_q.pop_front());
        end
      end else begin
        check_eq("done_pulse", done, 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("pc_at_done", pc, n);
        check_eq("carry_flag", carry_flag, mdl_carry);
        check_eq("div0_err", div0_err, mdl_div0);
      end
    end
    check_regs("run");
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  task automatic run_abort(input logic [4:0] plen);
    @(negedge clk);
    start    = 1'b1;
    prog_len = plen;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("abort_busy_pre", busy, 1);
    end
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_state("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      check_eq("abort_no_done", done, 0);
      check_eq("abort_no_busy", busy, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; prog_len = '0; prog_we = 1'b0;
    prog_addr = '0; prog_wdata = '0; dbg_sel = '0;
    n_checks = 0; n_errors = 0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 16'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;

    // Immediate program with a back-to-back dependency on r0.
    prog_buf.push_back(enc(A_ADD, 2'd0, 2'd0, 1'b1, 8'd5));
    prog_buf.push_back(enc(A_ADD, 2'd1, 2'd0, 1'b1, 8'd3));
    prog_buf.push_back(enc(A_SUB, 2'd2, 2'd1, 1'b0, 8'd0));
    load_buf();
    run_prog(5'd3, 0, '0);
    check_reg_const(0, 8'd5);
    check_reg_const(1, 8'd8);
    check_reg_const(2, 8'd3);
    check_eq("imm_carry_const", carry_flag, 0);

    // Reset keeps program memory: a re-run yields the same results.
    pulse_reset();
    run_prog(5'd3, 0, '0);
    check_reg_const(2, 8'd3);

    // start and prog_we while busy are ignored; re-run proves word 0 intact.
    run_prog(5'd3, 1, '0);
    run_prog(5'd3, 0, '0);

    // Overflow sets the carry flag.
    pulse_reset();
    prog_buf.push_back(enc(A_ADD, 2'd0, 2'd0, 1'b1, 8'd200));
    prog_buf.push_back(enc(A_ADD, 2'd1, 2'd0, 1'b1, 8'd100));
    load_buf();
    run_prog(5'd2, 0, '0);
    check_reg_const(1, 8'd44);
    check_eq("ovf_carry_const", carry_flag, 1);

    // Divide by zero is sticky until the next start.
    write_word(4'd0, enc(A_DIV, 2'd3, 2'd0, 1'b1, 8'd0));
    run_prog(5'd1, 0, '0);
    check_reg_const(3, 8'd0);
    repeat (5) @(negedge clk);
    check_eq("div0_sticky", div0_err, 1);
    run_prog(5'd0, 0, '0);
    check_eq("div0_cleared", div0_err, 0);

    // Word written on the start edge is the one fetched.
    run_prog(5'd1, 2, enc(A_XOR, 2'd2, 2'd2, 1'b1, 8'hA5));

    // Reset in the ISSUE cycle of instruction 2, then a clean restart.
    prog_buf.push_back(enc(A_ADD, 2'd0, 2'd0, 1'b1, 8'd5));
    prog_buf.push_back(enc(A_ADD, 2'd1, 2'd0, 1'b1, 8'd3));
    prog_buf.push_back(enc(A_SUB, 2'd2, 2'd1, 1'b0, 8'd0));
    load_buf();
    run_abort(5'd3);
    run_prog(5'd3, 0, '0);
    check_reg_const(1, 8'd8);

    // Random programs, lengths including ones beyond the memory depth.
    for (int iter = 0; iter < 8; iter++) begin
      for (int i = 0; i < 16; i++) prog_buf.push_back(16'($urandom));
      load_buf();
      run_prog(5'($urandom_range(1, 24)), 0, '0);
    end
    run_prog(5'd31, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
